// File: rtl/scanhalver_pkg.sv
// scanhalver_pkg: shared constants and helpers for the scanhalver line-rate halver.
//   HS/VS   : bit positions of hsync/vsync inside the 2-bit sync buses
//   ch_avg  : per-channel truncating average of two packed 3-channel RGB words
package scanhalver_pkg;

    localparam int HS    = 0;
    localparam int VS    = 1;
    localparam int AVG_W = 48;

    // Words are zero-extended to AVG_W; cw is the channel width (RGBW/3).
    // Each channel sum is formed in a full-width temporary, so it cannot overflow.
    function automatic logic [AVG_W-1:0] ch_avg(input logic [AVG_W-1:0] a, input logic [AVG_W-1:0] b, input int cw);
        logic [AVG_W-1:0] m;
        logic [AVG_W-1:0] s;
        logic [AVG_W-1:0] r;
        m = (AVG_W'(1) << cw) - AVG_W'(1);
        r = '0;
        for (int c = 0; c < 3; c++) begin
            s = ((a >> (c * cw)) & m) + ((b >> (c * cw)) & m);
            r = r | (((s >> 1) & m) << (c * cw));
        end
        return r;
    endfunction

endpackage

// File: rtl/scanhalver_linebuf.sv
// scanhalver_linebuf: two-bank line RAM, 2*2**HCW words of RGBW bits.
//   clock   : system clock
//   i_we    : write enable (input-pixel side)
//   i_waddr : {bank, pixel} write address
//   i_wdata : write word
//   i_raddr : {bank, pixel} output-side read address, o_rdata asynchronous read data
//   i_baddr/o_bdata : input-side read port, present only with SCANHALVER_LINE_BLEND_EN
module scanhalver_linebuf #(
    parameter int HCW  = 9,
    parameter int RGBW = 18
) (
    input  logic            clock,
    input  logic            i_we,
    input  logic [HCW:0]    i_waddr,
    input  logic [RGBW-1:0] i_wdata,
    input  logic [HCW:0]    i_raddr,
    output logic [RGBW-1:0] o_rdata
`ifdef SCANHALVER_LINE_BLEND_EN
    ,
    input  logic [HCW:0]    i_baddr,
    output logic [RGBW-1:0] o_bdata
`endif
);

    logic [RGBW-1:0] r_mem [0:(2**(HCW+1))-1];

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
`ifdef SCANHALVER_LINE_BLEND_EN
    assign o_bdata = r_mem[i_baddr];
`endif

endmodule

// File: rtl/scanhalver.sv
// scanhalver: converts a ~31 kHz sync/RGB stream (ice) into a 15 kHz stream (oce) by
// keeping one of every two input lines and replaying it over two input line times.
//   clock  : system clock            reset : asynchronous active-low reset
//   bypass : 1 = osync/orgb follow isync/irgb combinationally
//   ice    : input pixel enable      isync : [0]=hsync [1]=vsync, irgb : input pixel
//   oce    : output pixel enable     osync : [0]=halved hsync [1]=vsync, orgb : output pixel
// Optional macro SCANHALVER_LINE_BLEND_EN: odd lines are averaged into the kept line
// instead of being dropped.
module scanhalver
    import scanhalver_pkg::*;
#(
    parameter int HCW  = 9,
    parameter int RGBW = 18
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            bypass,
    input  logic            ice,
    input  logic [1:0]      isync,
    input  logic [RGBW-1:0] irgb,
    input  logic            oce,
    output logic [1:0]      osync,
    output logic [RGBW-1:0] orgb
);

`ifdef SCANHALVER_LINE_BLEND_EN
    localparam logic END_PAR = 1'b1;
`else
    localparam logic END_PAR = 1'b0;
`endif

    logic [1:0]      r_isync_d;
    logic            r_hs_pos;
    logic            r_hs_neg;
    logic            r_vs_neg;
    logic [HCW-1:0]  r_ihc;
    logic [HCW-1:0]  r_hbeg;
    logic [HCW-1:0]  r_hend;
    logic [HCW-1:0]  r_ohc;
    logic            r_parity;
    logic            r_wbank;
    logic            r_pending;
    logic            r_ohs;
    logic            r_ovs;
    logic [RGBW-1:0] r_brgb;
    logic [RGBW-1:0] w_rdata;
    logic            w_line_end;
    logic            w_we;
    logic [HCW:0]    w_waddr;
    logic [RGBW-1:0] w_wdata;

    // The line that just completed is the one replayed; its bank flips to the read side.
    assign w_line_end = ice & r_hs_neg & (r_parity == END_PAR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_isync_d <= '0;
            r_hs_pos  <= 1'b0;
            r_hs_neg  <= 1'b0;
            r_vs_neg  <= 1'b0;
            r_ihc     <= '0;
            r_hbeg    <= '0;
            r_hend    <= '0;
            r_parity  <= 1'b0;
            r_wbank   <= 1'b0;
        end else if (ice) begin
            r_isync_d <= isync;
            r_hs_pos  <= isync[HS] & ~r_isync_d[HS];
            r_hs_neg  <= ~isync[HS] & r_isync_d[HS];
            r_vs_neg  <= ~isync[VS] & r_isync_d[VS];
            r_ihc     <= r_hs_neg ? '0 : r_ihc + 1'b1;
            if (r_hs_pos) r_hbeg <= r_ihc;
            if (r_hs_neg) r_hend <= r_ihc;
            r_parity  <= r_vs_neg ? 1'b0 : r_parity ^ r_hs_neg;
            r_wbank   <= r_wbank ^ w_line_end;
        end
    end

    // A line end landing on the consuming oce keeps the request alive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_pending <= 1'b0;
        else        r_pending <= w_line_end | (r_pending & ~oce);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ohc  <= '0;
            r_brgb <= '0;
            r_ohs  <= 1'b0;
            r_ovs  <= 1'b0;
        end else if (oce) begin
            r_ohc  <= r_pending ? '0 : r_ohc + 1'b1;
            r_brgb <= w_rdata;
            r_ohs  <= (r_ohc == r_hbeg) | (r_ohs & (r_ohc != r_hend));
            r_ovs  <= isync[VS];
        end
    end

`ifdef SCANHALVER_LINE_BLEND_EN
    logic            r_wv;
    logic            r_wblend;
    logic [HCW:0]    r_waddr;
    logic [RGBW-1:0] r_wd;
    logic [RGBW-1:0] r_bd;
    logic [RGBW-1:0] w_bdata;

    // Every write is pushed one ice late so the odd-line read-modify-write and the
    // plain even-line write share one write port at the delayed address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wv     <= 1'b0;
            r_wblend <= 1'b0;
            r_waddr  <= '0;
            r_wd     <= '0;
            r_bd     <= '0;
        end else if (ice) begin
            r_wv     <= 1'b1;
            r_wblend <= r_parity;
            r_waddr  <= {r_wbank, r_ihc};
            r_wd     <= irgb;
            r_bd     <= w_bdata;
        end
    end

    assign w_we    = ice & r_wv;
    assign w_waddr = r_waddr;
    assign w_wdata = r_wblend ? RGBW'(ch_avg(AVG_W'(r_bd), AVG_W'(r_wd), RGBW / 3)) : r_wd;
`else
    assign w_we    = ice & ~r_parity;
    assign w_waddr = {r_wbank, r_ihc};
    assign w_wdata = irgb;
`endif

    scanhalver_linebuf #(.HCW(HCW), .RGBW(RGBW)) u_linebuf (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr ({~r_wbank, r_ohc}),
        .o_rdata (w_rdata)
`ifdef SCANHALVER_LINE_BLEND_EN
        ,
        .i_baddr ({r_wbank, r_ihc}),
        .o_bdata (w_bdata)
`endif
    );

    assign osync = bypass ? isync : {r_ovs, r_ohs};
    assign orgb  = bypass ? irgb : r_brgb;

endmodule

// File: tb/tb_scanhalver.sv
// tb_scanhalver: self-checking bench for scanhalver (default build, line drop).
module tb_scanhalver;

    localparam int HCW  = 9;
    localparam int RGBW = 18;
    localparam int L    = 400;
    localparam int A    = 300;
    localparam int B    = 340;
    localparam int NL   = 24;
    localparam int NT   = NL * L;
    localparam int BEG  = A - B - 1 + L;
    localparam int ENDC = L - 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            bypass = 1'b0;
    logic            ice = 1'b0;
    logic            oce = 1'b0;
    logic [1:0]      isync = 2'b00;
    logic [RGBW-1:0] irgb = '0;
    logic [1:0]      osync;
    logic [RGBW-1:0] orgb;

    always #5 clock = ~clock;

    scanhalver #(.HCW(HCW), .RGBW(RGBW)) dut (
        .clock  (clock),
        .reset  (reset),
        .bypass (bypass),
        .ice    (ice),
        .isync  (isync),
        .irgb   (irgb),
        .oce    (oce),
        .osync  (osync),
        .orgb   (orgb)
    );

    typedef struct {
        logic            byp;
        logic [1:0]      s;
        logic [RGBW-1:0] rgb;
        logic [1:0]      exp_s;
        logic [RGBW-1:0] exp_rgb;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [RGBW-1:0] seg_data [0:NL][0:L-1];
    int              seg_par  [0:NL];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line-end events: hsync falls at q==B, seen one ice later.
    function automatic int te(input int s);
        return s * L + B + 1;
    endfunction

    function automatic int seg_of(input int t);
        return (t <= B + 1) ? 0 : (t - B - 2) / L + 1;
    endfunction

    function automatic int addr_of(input int t);
        return (t <= B + 1) ? t : (t - B - 2) % L;
    endfunction

    function automatic int cnt_of(input int s);
        return (s == 0) ? B + 2 : L;
    endfunction

    initial begin
        vec_t vt [0:7];
        vt[0] = '{1'b0, 2'b11, 18'h3FFFF, 2'b00, 18'h00000};
        vt[1] = '{1'b1, 2'b01, 18'h12345, 2'b01, 18'h12345};
        vt[2] = '{1'b1, 2'b10, 18'h00001, 2'b10, 18'h00001};
        vt[3] = '{1'b1, 2'b11, 18'h3FFFF, 2'b11, 18'h3FFFF};
        vt[4] = '{1'b0, 2'b01, 18'h2AAAA, 2'b00, 18'h00000};
        vt[5] = '{1'b1, 2'b00, 18'h00000, 2'b00, 18'h00000};
        vt[6] = '{1'b1, 2'b10, 18'h15555, 2'b10, 18'h15555};
        vt[7] = '{1'b0, 2'b10, 18'h0F0F0, 2'b00, 18'h00000};

        seg_par[0] = 0;
        for (int s = 0; s < NL; s++) seg_par[s+1] = (s % 8 == 2) ? 0 : 1 - seg_par[s];

        for (int i = 0; i < 6; i++) begin
            ice = 1'b1;
            oce = i[0];
            isync = 2'($urandom);
            irgb = RGBW'($urandom);
            @(posedge clock);
            #1;
        end
        chk("reset_osync", 32'(osync), 32'd0);
        chk("reset_orgb", 32'(orgb), 32'd0);
        reset = 1'b1;

        for (int t = 0; t < NT; t++) begin
            int q, ln, s, lk, rl, p;
            logic hs, vs;
            q = t % L;
            ln = t / L;
            s = seg_of(t);
            hs = (q >= A) && (q < B);
            vs = (ln % 8 == 0) || (ln % 8 == 1) || ((ln % 8 == 2) && (q < B));
            isync = {vs, hs};
            ice = 1'b1;
            oce = (t % 2 == 0);
            irgb = (seg_par[s] != 0) ? '1 : RGBW'($urandom_range(0, (1 << RGBW) - 2));
            seg_data[s][addr_of(t)] = irgb;
            @(posedge clock);
            #1;
            if (oce) begin
                chk("vsync_out", 32'(osync[1]), 32'(vs));
                lk = -1;
                rl = -1;
                for (int k = 0; k <= NL; k++) begin
                    if (seg_par[k] == 0 && te(k) < t) lk = k;
                    if (seg_par[k] == 0 && te(k) + 1 < t) rl = te(k) + 1;
                end
                if (lk >= 0 && rl >= 0) begin
                    p = (t - rl) / 2 - 1;
                    if (p < cnt_of(lk)) chk("orgb_replay", 32'(orgb), 32'(seg_data[lk][p]));
                    if (t >= 2000) chk("ohs", 32'(osync[0]), 32'((p >= BEG) && (p < ENDC)));
                end
            end
        end

        reset = 1'b0;
        #1;
        chk("midline_reset_osync", 32'(osync), 32'd0);
        chk("midline_reset_orgb", 32'(orgb), 32'd0);
        for (int i = 0; i < 4; i++) begin
            oce = i[0];
            isync = 2'($urandom);
            @(posedge clock);
            #1;
        end
        chk("held_reset_osync", 32'(osync), 32'd0);
        chk("held_reset_orgb", 32'(orgb), 32'd0);

        for (int i = 0; i < 8; i++) begin
            bypass = vt[i].byp;
            isync = vt[i].s;
            irgb = vt[i].rgb;
            #1;
            chk("table_osync", 32'(osync), 32'(vt[i].exp_s));
            chk("table_orgb", 32'(orgb), 32'(vt[i].exp_rgb));
        end

        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bypass = 1'b1;
            oce = i[0];
            isync = 2'($urandom);
            irgb = RGBW'($urandom);
            #1;
            chk("rand_bypass_osync", 32'(osync), 32'(isync));
            chk("rand_bypass_orgb", 32'(orgb), 32'(irgb));
            @(posedge clock);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
